// File: rtl/enemy_behavior_ctrl_pkg.sv
// Shared types, default tuning constants and small arithmetic helpers for the
// enemy behaviour sequencer.
package enemy_pkg;

  typedef enum logic [1:0] {
    BEH_STAND  = 2'd0,
    BEH_WALK   = 2'd1,
    BEH_ATTACK = 2'd2
  } behavior_t;

  typedef enum logic [1:0] {
    ST_STAND    = 2'd0,
    ST_WALK     = 2'd1,
    ST_ATTACK   = 2'd2,
    ST_COOLDOWN = 2'd3
  } enemy_state_t;

  localparam logic [7:0] DEF_INIT_X       = 8'd120;
  localparam logic [7:0] DEF_INIT_Y       = 8'd100;
  localparam logic [7:0] DEF_SIGHT_RANGE  = 8'd64;
  localparam logic [7:0] DEF_ATTACK_RANGE = 8'd12;
  localparam logic [7:0] DEF_Y_RANGE      = 8'd8;
  localparam logic [7:0] DEF_WALK_STEP    = 8'd1;
  localparam int         DEF_FRAMES_PER_STEP = 4;
  localparam int         DEF_COOLDOWN_FRAMES = 16;
  localparam logic [7:0] DEF_X_MIN        = 8'd8;
  localparam logic [7:0] DEF_X_MAX        = 8'd240;

  // Unsigned distance widened to 9 bits so it can never wrap.
  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    if (a >= b) begin
      d = {1'b0, a} - {1'b0, b};
    end else begin
      d = {1'b0, b} - {1'b0, a};
    end
    return d;
  endfunction

  function automatic logic [7:0] clamp_x(input logic [7:0] x, input logic [7:0] lo,
                                         input logic [7:0] hi);
    logic [7:0] r;
    if (x < lo) begin
      r = lo;
    end else if (x > hi) begin
      r = hi;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/enemy_behavior_ctrl_if.sv
// Frame/AI control inputs and sprite-lookup outputs of one enemy controller.
interface enemy_behavior_ctrl_if;
  logic       frame_tick;
  logic       enable;
  logic       spawn;
  logic [7:0] spawn_x;
  logic [7:0] spawn_y;
  logic [7:0] player_x;
  logic [7:0] player_y;
  logic [7:0] enemy_x;
  logic [7:0] enemy_y;
  logic [1:0] behavior;
  logic       isLeft;
  logic [1:0] period;
  logic       attack_hit;

  modport master (
    output frame_tick, enable, spawn, spawn_x, spawn_y, player_x, player_y,
    input  enemy_x, enemy_y, behavior, isLeft, period, attack_hit
  );

  modport slave (
    input  frame_tick, enable, spawn, spawn_x, spawn_y, player_x, player_y,
    output enemy_x, enemy_y, behavior, isLeft, period, attack_hit
  );
endinterface

// File: rtl/enemy_behavior_ctrl_anim_period_counter.sv
// Tick-gated divide-by-FRAMES_PER_STEP feeding a 2-bit animation period.
// wrap flags that the next tick rolls the step counter over.
module anim_period_counter #(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       clear,
  output logic [1:0] period,
  output logic       wrap
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       period_r;

  // Step counter and period register; clear dominates tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      period_r <= 2'd0;
    end else if (clear) begin
      cnt_r    <= '0;
      period_r <= 2'd0;
    end else if (tick) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r    <= '0;
        period_r <= period_r + 2'd1;
      end else begin
        cnt_r    <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign period = period_r;
  assign wrap   = (cnt_r == CNT_LAST);

endmodule

// File: rtl/enemy_behavior_ctrl.sv
// Per-enemy stand/walk/attack sequencer producing draw origin, facing,
// animation period and a one-clock strike pulse, advanced once per frame tick.
module enemy_behavior_ctrl
  import enemy_pkg::*;
#(
  parameter logic [7:0] INIT_X          = DEF_INIT_X,
  parameter logic [7:0] INIT_Y          = DEF_INIT_Y,
  parameter logic [7:0] SIGHT_RANGE     = DEF_SIGHT_RANGE,
  parameter logic [7:0] ATTACK_RANGE    = DEF_ATTACK_RANGE,
  parameter logic [7:0] Y_RANGE         = DEF_Y_RANGE,
  parameter logic [7:0] WALK_STEP       = DEF_WALK_STEP,
  parameter int         FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
  parameter int         COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter logic [7:0] X_MIN           = DEF_X_MIN,
  parameter logic [7:0] X_MAX           = DEF_X_MAX
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  enemy_behavior_ctrl_if.slave bus
);

  localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_FRAMES - 1);

  enemy_state_t    state_r;
  behavior_t       behavior_r;
  logic [7:0]      x_r;
  logic [7:0]      y_r;
  logic            is_left_r;
  logic            attack_hit_r;
  logic [CD_W-1:0] cool_r;

  logic [8:0] dx_s;
  logic [8:0] dy_s;
  logic       in_sight_s;
  logic       in_range_s;
  logic       left_s;
  logic [7:0] step_s;
  logic [8:0] sum_s;
  logic [7:0] walk_x_s;
  logic       cnt_adv_s;
  logic       cnt_clr_s;
  logic [1:0] period_s;
  logic       wrap_s;

  assign dx_s       = abs_diff(bus.player_x, x_r);
  assign dy_s       = abs_diff(bus.player_y, y_r);
  assign in_sight_s = (dx_s <= {1'b0, SIGHT_RANGE})  && (dy_s <= {1'b0, Y_RANGE});
  assign in_range_s = (dx_s <= {1'b0, ATTACK_RANGE}) && (dy_s <= {1'b0, Y_RANGE});
  assign left_s     = (bus.player_x < x_r);
  assign step_s     = (dx_s < {1'b0, WALK_STEP}) ? dx_s[7:0] : WALK_STEP;
  assign sum_s      = {1'b0, x_r} + {1'b0, step_s};

  // Next walking position: step toward the player, never beyond the legal span.
  always_comb begin
    walk_x_s = x_r;
    if (left_s) begin
      if ({1'b0, x_r} >= ({1'b0, X_MIN} + {1'b0, step_s})) begin
        walk_x_s = x_r - step_s;
      end else begin
        walk_x_s = X_MIN;
      end
    end else begin
      if (sum_s > {1'b0, X_MAX}) begin
        walk_x_s = X_MAX;
      end else begin
        walk_x_s = sum_s[7:0];
      end
    end
  end

  // Animation counter runs only while walking on or attacking; otherwise held at zero.
  always_comb begin
    cnt_adv_s = 1'b0;
    cnt_clr_s = 1'b0;
    if (bus.spawn) begin
      cnt_clr_s = 1'b1;
    end else if (bus.frame_tick) begin
      if (!bus.enable) begin
        cnt_clr_s = 1'b1;
      end else begin
        case (state_r)
          ST_WALK: begin
            if (in_range_s || !in_sight_s) begin
              cnt_clr_s = 1'b1;
            end else begin
              cnt_adv_s = 1'b1;
            end
          end
          ST_ATTACK: cnt_adv_s = 1'b1;
          default:   cnt_clr_s = 1'b1;
        endcase
      end
    end else begin
      cnt_adv_s = 1'b0;
    end
  end

  anim_period_counter #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_period (
    .clk   (Clk),
    .rst_n (Reset_n),
    .tick  (cnt_adv_s),
    .clear (cnt_clr_s),
    .period(period_s),
    .wrap  (wrap_s)
  );

  // Behaviour FSM with position, facing, cooldown and strike pulse registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= ST_STAND;
      behavior_r   <= BEH_STAND;
      x_r          <= INIT_X;
      y_r          <= INIT_Y;
      is_left_r    <= 1'b0;
      attack_hit_r <= 1'b0;
      cool_r       <= '0;
    end else begin
      attack_hit_r <= 1'b0;
      if (bus.spawn) begin
        state_r    <= ST_STAND;
        behavior_r <= BEH_STAND;
        x_r        <= clamp_x(bus.spawn_x, X_MIN, X_MAX);
        y_r        <= bus.spawn_y;
        cool_r     <= '0;
      end else if (bus.frame_tick) begin
        if (!bus.enable) begin
          state_r    <= ST_STAND;
          behavior_r <= BEH_STAND;
          cool_r     <= '0;
        end else begin
          case (state_r)
            ST_STAND: begin
              if (dx_s != 9'd0) begin
                is_left_r <= left_s;
              end
              if (in_range_s) begin
                state_r    <= ST_ATTACK;
                behavior_r <= BEH_ATTACK;
              end else if (in_sight_s) begin
                state_r    <= ST_WALK;
                behavior_r <= BEH_WALK;
              end
            end
            ST_WALK: begin
              if (dx_s != 9'd0) begin
                is_left_r <= left_s;
              end
              if (in_range_s) begin
                state_r    <= ST_ATTACK;
                behavior_r <= BEH_ATTACK;
              end else if (!in_sight_s) begin
                state_r    <= ST_STAND;
                behavior_r <= BEH_STAND;
              end else begin
                x_r <= walk_x_s;
              end
            end
            ST_ATTACK: begin
              // The strike lands on the 1->2 period step; the last period rolls into cooldown.
              if (wrap_s && (period_s == 2'd1)) begin
                attack_hit_r <= 1'b1;
              end
              if (wrap_s && (period_s == 2'd3)) begin
                state_r    <= ST_COOLDOWN;
                behavior_r <= BEH_STAND;
                cool_r     <= '0;
              end
            end
            ST_COOLDOWN: begin
              if (cool_r == CD_LAST) begin
                state_r    <= ST_STAND;
                behavior_r <= BEH_STAND;
                cool_r     <= '0;
              end else begin
                cool_r <= cool_r + CD_W'(1);
              end
            end
            default: begin
              state_r    <= ST_STAND;
              behavior_r <= BEH_STAND;
              cool_r     <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.enemy_x    = x_r;
  assign bus.enemy_y    = y_r;
  assign bus.behavior   = behavior_r;
  assign bus.isLeft     = is_left_r;
  assign bus.period     = period_s;
  assign bus.attack_hit = attack_hit_r;

endmodule

// File: tb/tb_enemy_behavior_ctrl.sv
// Directed bench for enemy_behavior_ctrl: idle, walk, attack/cooldown, enable
// abort, edge clamping, spawn priority and asynchronous reset.
module tb_enemy_behavior_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  enemy_behavior_ctrl_if bus();

  enemy_behavior_ctrl dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
  endtask

  task automatic do_spawn(input logic [7:0] sx, input logic [7:0] sy, input logic with_tick);
    @(negedge clk);
    bus.spawn      = 1'b1;
    bus.spawn_x    = sx;
    bus.spawn_y    = sy;
    bus.frame_tick = with_tick;
    @(negedge clk);
    bus.spawn      = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_x"},      bus.enemy_x, 120);
    check_val({tag, "_y"},      bus.enemy_y, 100);
    check_val({tag, "_beh"},    bus.behavior, 0);
    check_val({tag, "_left"},   bus.isLeft, 0);
    check_val({tag, "_period"}, bus.period, 0);
    check_val({tag, "_hit"},    bus.attack_hit, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.enable     = 1'b1;
    bus.spawn      = 1'b0;
    bus.spawn_x    = 8'd0;
    bus.spawn_y    = 8'd0;
    bus.player_x   = 8'd200;
    bus.player_y   = 8'd100;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Player out of sight (dx=80): stays standing.
    for (int i = 0; i < 100; i++) begin
      tick();
      check_val("idle_beh", bus.behavior, 0);
      check_val("idle_hit", bus.attack_hit, 0);
    end
    check_val("idle_x", bus.enemy_x, 120);
    check_val("idle_period", bus.period, 0);

    // Player at 60: notice, then walk left one pixel per tick.
    bus.player_x = 8'd60;
    tick();
    check_val("notice_beh", bus.behavior, 1);
    check_val("notice_left", bus.isLeft, 1);
    check_val("notice_x", bus.enemy_x, 120);
    for (int k = 1; k <= 48; k++) begin
      tick();
      check_val("walk_x", bus.enemy_x, 120 - k);
      check_val("walk_period", bus.period, (k / 4) % 4);
      check_val("walk_beh", bus.behavior, 1);
    end

    // dx=12 now: attack starts without moving.
    tick();
    check_val("atk_beh", bus.behavior, 2);
    check_val("atk_period", bus.period, 0);
    check_val("atk_x", bus.enemy_x, 72);
    for (int a = 1; a <= 16; a++) begin
      tick();
      check_val("atk_seq_beh", bus.behavior, (a < 16) ? 2 : 0);
      check_val("atk_seq_period", bus.period, (a < 16) ? (a / 4) % 4 : 0);
      check_val("atk_seq_hit", bus.attack_hit, (a == 8) ? 1 : 0);
      check_val("atk_seq_x", bus.enemy_x, 72);
      check_val("atk_seq_left", bus.isLeft, 1);
      if (a == 8) begin
        @(negedge clk);
        check_val("hit_one_clk", bus.attack_hit, 0);
      end
      if (a == 6) begin
        repeat (6) @(negedge clk);
        check_val("no_tick_period", bus.period, 1);
        check_val("no_tick_beh", bus.behavior, 2);
      end
    end

    // Cooldown lasts 16 ticks, then the still-in-range player is attacked again.
    for (int c = 1; c <= 16; c++) begin
      tick();
      check_val("cool_beh", bus.behavior, 0);
      check_val("cool_period", bus.period, 0);
      check_val("cool_hit", bus.attack_hit, 0);
    end
    tick();
    check_val("reattack_beh", bus.behavior, 2);
    check_val("reattack_period", bus.period, 0);

    // Drop enable at period 1: attack aborted with no strike.
    repeat (4) tick();
    check_val("pre_abort_period", bus.period, 1);
    bus.enable = 1'b0;
    tick();
    check_val("abort_beh", bus.behavior, 0);
    check_val("abort_period", bus.period, 0);
    check_val("abort_hit", bus.attack_hit, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val("disabled_beh", bus.behavior, 0);
      check_val("disabled_hit", bus.attack_hit, 0);
    end
    bus.enable = 1'b1;

    // Walk right into X_MAX: position clamps while animation keeps running.
    bus.player_x = 8'd255;
    do_spawn(8'd230, 8'd100, 1'b0);
    check_val("spawn_x", bus.enemy_x, 230);
    check_val("spawn_beh", bus.behavior, 0);
    tick();
    check_val("clamp_walk_beh", bus.behavior, 1);
    check_val("clamp_walk_left", bus.isLeft, 0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      check_val("clamp_x", bus.enemy_x, (230 + k > 240) ? 240 : 230 + k);
      check_val("clamp_beh", bus.behavior, 1);
      check_val("clamp_period", bus.period, (k / 4) % 4);
    end

    // Spawn with a simultaneous tick mid-walk: spawn wins, x clamped high.
    do_spawn(8'd250, 8'd50, 1'b1);
    check_val("spawn_hi_x", bus.enemy_x, 240);
    check_val("spawn_hi_y", bus.enemy_y, 50);
    check_val("spawn_hi_beh", bus.behavior, 0);
    check_val("spawn_hi_period", bus.period, 0);
    tick();
    check_val("far_y_beh", bus.behavior, 0);
    do_spawn(8'd3, 8'd100, 1'b0);
    check_val("spawn_lo_x", bus.enemy_x, 8);

    // Asynchronous reset in the middle of an attack.
    bus.player_x = 8'd95;
    do_spawn(8'd100, 8'd100, 1'b0);
    tick();
    check_val("pre_rst_beh", bus.behavior, 2);
    check_val("pre_rst_left", bus.isLeft, 1);
    repeat (9) tick();
    check_val("pre_rst_period", bus.period, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
